// File: rtl/argon_pkg.sv
// Shared types and constants for the Argon bus sequencer: data word, unit
// select IDs, sequencer state encoding and request legality helper.
package argon_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [3:0]        unit_id_t;

    // ID_NONE selects no unit, so the bus is idle whenever it is driven.
    localparam unit_id_t ID_NONE    = 4'h0;
    localparam unit_id_t ID_REGFILE = 4'h1;
    localparam unit_id_t ID_ALU     = 4'h2;
    localparam unit_id_t ID_MEM     = 4'h3;
    localparam unit_id_t ID_IO      = 4'h4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SOURCE   = 3'd1,
        TRANSFER = 3'd2,
        DONE     = 3'd3,
        ABORT    = 3'd4
    } seq_state_t;

    function automatic logic req_is_legal(input unit_id_t src, input unit_id_t dst);
        return (src != ID_NONE) && (dst != ID_NONE) && (src != dst);
    endfunction

endpackage

// File: rtl/argon_bus_seq.sv
// Bus transfer sequencer: moves one word from a source unit to a destination
// unit over the shared bus, with retry on dropped valid and a timeout abort.
module argon_bus_seq
    import argon_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic [3:0] i_src_id,
    input  logic [3:0] i_src_cmd,
    input  logic [3:0] i_dst_id,
    input  logic [3:0] i_dst_cmd,
    output logic [3:0] write_id,
    output logic [3:0] write_command,
    output logic [3:0] read_id,
    output logic [3:0] read_command,
    input  logic       i_bus_valid,
    input  word_t      i_bus_data,
    output word_t      o_last_data,
    output logic       o_done,
    output logic       o_timeout,
    output logic       o_error,
    output logic       o_busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_src_id;
    logic [3:0]       r_src_cmd;
    logic [3:0]       r_dst_id;
    logic [3:0]       r_dst_cmd;
    word_t            r_last_data;
    logic             r_req_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_timeout;
    logic             r_error;
    logic [3:0]       r_write_id;
    logic [3:0]       r_write_cmd;
    logic [3:0]       r_read_id;
    logic [3:0]       r_read_cmd;

    seq_state_t       w_next_state;
    logic [CNT_W-1:0] w_cnt_next;
    logic [3:0]       w_src_id_n;
    logic [3:0]       w_src_cmd_n;
    logic [3:0]       w_dst_id_n;
    logic [3:0]       w_dst_cmd_n;
    logic             w_accept;
    logic             w_capture;
    logic             w_timeout_hit;
    logic             w_illegal;
    logic [3:0]       w_write_id;
    logic [3:0]       w_write_cmd;
    logic [3:0]       w_read_id;
    logic [3:0]       w_read_cmd;

    // Next-state, counter and request-latch logic.
    always_comb begin
        w_next_state  = r_state;
        w_cnt_next    = r_cnt;
        w_src_id_n    = r_src_id;
        w_src_cmd_n   = r_src_cmd;
        w_dst_id_n    = r_dst_id;
        w_dst_cmd_n   = r_dst_cmd;
        w_accept      = i_req_valid & r_req_ready;
        w_capture     = 1'b0;
        w_timeout_hit = 1'b0;
        w_illegal     = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_src_id_n  = i_src_id;
                    w_src_cmd_n = i_src_cmd;
                    w_dst_id_n  = i_dst_id;
                    w_dst_cmd_n = i_dst_cmd;
                    w_cnt_next  = '0;
                    if (req_is_legal(i_src_id, i_dst_id)) begin
                        w_next_state = SOURCE;
                    end else begin
                        w_next_state = ABORT;
                        w_illegal    = 1'b1;
                    end
                end else begin
                    w_next_state = IDLE;
                end
            end
            SOURCE: begin
                if (r_cnt == CNT_LAST) begin
                    w_next_state  = ABORT;
                    w_timeout_hit = 1'b1;
                end else begin
                    w_cnt_next   = r_cnt + CNT_W'(1);
                    w_next_state = i_bus_valid ? TRANSFER : SOURCE;
                end
            end
            TRANSFER: begin
                // A completing edge beats a timeout landing on the same cycle.
                if (i_bus_valid) begin
                    w_next_state = DONE;
                    w_capture    = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_next_state  = ABORT;
                    w_timeout_hit = 1'b1;
                end else begin
                    w_cnt_next   = r_cnt + CNT_W'(1);
                    w_next_state = SOURCE;
                end
            end
            DONE:    w_next_state = IDLE;
            ABORT:   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Bus drive values for the state being entered, so they can be registered.
    always_comb begin
        w_write_id  = ID_NONE;
        w_write_cmd = 4'h0;
        w_read_id   = ID_NONE;
        w_read_cmd  = 4'h0;
        case (w_next_state)
            SOURCE: begin
                w_write_id  = w_src_id_n;
                w_write_cmd = w_src_cmd_n;
            end
            TRANSFER: begin
                w_write_id  = w_src_id_n;
                w_write_cmd = w_src_cmd_n;
                w_read_id   = w_dst_id_n;
                w_read_cmd  = w_dst_cmd_n;
            end
            default: begin
                w_write_id  = ID_NONE;
                w_write_cmd = 4'h0;
                w_read_id   = ID_NONE;
                w_read_cmd  = 4'h0;
            end
        endcase
    end

    // State, latched request, captured data and registered outputs.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_src_id    <= ID_NONE;
            r_src_cmd   <= 4'h0;
            r_dst_id    <= ID_NONE;
            r_dst_cmd   <= 4'h0;
            r_last_data <= '0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_error     <= 1'b0;
            r_write_id  <= ID_NONE;
            r_write_cmd <= 4'h0;
            r_read_id   <= ID_NONE;
            r_read_cmd  <= 4'h0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_cnt_next;
            r_src_id    <= w_src_id_n;
            r_src_cmd   <= w_src_cmd_n;
            r_dst_id    <= w_dst_id_n;
            r_dst_cmd   <= w_dst_cmd_n;
            if (w_capture) begin
                r_last_data <= i_bus_data;
            end
            r_req_ready <= (w_next_state == IDLE);
            r_busy      <= (w_next_state != IDLE);
            r_done      <= (w_next_state == DONE);
            r_timeout   <= w_timeout_hit;
            r_error     <= w_illegal;
            r_write_id  <= w_write_id;
            r_write_cmd <= w_write_cmd;
            r_read_id   <= w_read_id;
            r_read_cmd  <= w_read_cmd;
        end
    end

    assign o_req_ready   = r_req_ready;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_timeout     = r_timeout;
    assign o_error       = r_error;
    assign o_last_data   = r_last_data;
    assign write_id      = r_write_id;
    assign write_command = r_write_cmd;
    assign read_id       = r_read_id;
    assign read_command  = r_read_cmd;

endmodule

// File: tb/tb_argon_bus_seq.sv
// Directed testbench for argon_bus_seq: hand-computed cycle timing of each
// transfer scenario, relative to the accept cycle (cycle 0).
module tb_argon_bus_seq;
    import argon_pkg::*;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] src_id, src_cmd, dst_id, dst_cmd;
    logic [3:0] write_id, write_command, read_id, read_command;
    logic       bus_valid;
    word_t      bus_data;
    word_t      last_data;
    logic       done, timeout, error, busy;

    int n_checks;
    int n_errors;

    int done_cyc, to_cyc, err_cyc, read_first;
    int n_done, n_to, n_err, n_read, n_bus;
    logic [3:0] wid_log [32];
    logic [3:0] wcmd_log [32];
    logic [3:0] rcmd_log [32];
    logic       rdy_log [32];

    argon_bus_seq #(.TIMEOUT_CYCLES(16)) dut (
        .i_Clk         (clk),
        .i_Reset       (rst),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_src_id      (src_id),
        .i_src_cmd     (src_cmd),
        .i_dst_id      (dst_id),
        .i_dst_cmd     (dst_cmd),
        .write_id      (write_id),
        .write_command (write_command),
        .read_id       (read_id),
        .read_command  (read_command),
        .i_bus_valid   (bus_valid),
        .i_bus_data    (bus_data),
        .o_last_data   (last_data),
        .o_done        (done),
        .o_timeout     (timeout),
        .o_error       (error),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present a request during cycle 0, then scramble the request inputs.
    task automatic start_req(input logic [3:0] s, input logic [3:0] sc,
                             input logic [3:0] d, input logic [3:0] dc);
        req_valid = 1'b1;
        src_id = s; src_cmd = sc; dst_id = d; dst_cmd = dc;
        bus_valid = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        src_id = ID_IO; src_cmd = 4'hF; dst_id = ID_IO; dst_cmd = 4'hE;
    endtask

    // Observe cycles 1..ncyc; bus_valid during cycle c is mask[c].
    task automatic run_cycles(input int ncyc, input logic [31:0] mask);
        done_cyc = 0; to_cyc = 0; err_cyc = 0; read_first = 0;
        n_done = 0; n_to = 0; n_err = 0; n_read = 0; n_bus = 0;
        for (int c = 1; c <= ncyc; c++) begin
            wid_log[c]  = write_id;
            wcmd_log[c] = write_command;
            rcmd_log[c] = read_command;
            rdy_log[c]  = req_ready;
            if (done)    begin n_done++; if (done_cyc == 0) done_cyc = c; end
            if (timeout) begin n_to++;   if (to_cyc == 0)   to_cyc = c;   end
            if (error)   begin n_err++;  if (err_cyc == 0)  err_cyc = c;  end
            if (read_id != ID_NONE) begin n_read++; if (read_first == 0) read_first = c; end
            if (write_id != ID_NONE || read_id != ID_NONE || write_command != 4'h0 || read_command != 4'h0)
                n_bus++;
            bus_valid = mask[c];
            @(negedge clk);
        end
        bus_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        rst = 1'b1; req_valid = 1'b0; bus_valid = 1'b0; bus_data = 16'h0000;
        src_id = 4'h0; src_cmd = 4'h0; dst_id = 4'h0; dst_cmd = 4'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_val("rst_ready", {31'd0, req_ready}, 32'd1);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_pulses", {29'd0, done, timeout, error}, 32'd0);
        check_val("rst_last", {16'd0, last_data}, 32'h0);
        check_val("rst_bus", {16'd0, write_id, write_command, read_id, read_command}, 32'h0);

        // Minimum-latency transfer REGFILE -> ALU.
        bus_data = 16'h1234;
        start_req(ID_REGFILE, 4'd2, ID_ALU, 4'd1);
        run_cycles(5, 32'hFFFF_FFFE);
        check_val("t1_wid_c1", {28'd0, wid_log[1]}, {28'd0, ID_REGFILE});
        check_val("t1_wcmd_c1", {28'd0, wcmd_log[1]}, 32'd2);
        check_val("t1_read_first", read_first, 32'd2);
        check_val("t1_n_read", n_read, 32'd1);
        check_val("t1_rcmd_c2", {28'd0, rcmd_log[2]}, 32'd1);
        check_val("t1_done_cyc", done_cyc, 32'd3);
        check_val("t1_n_done", n_done, 32'd1);
        check_val("t1_last", {16'd0, last_data}, 32'h1234);
        check_val("t1_rdy_c3", {31'd0, rdy_log[3]}, 32'd0);
        check_val("t1_rdy_c4", {31'd0, rdy_log[4]}, 32'd1);

        // Source valid arrives in cycle 6.
        bus_data = 16'hBEEF;
        start_req(ID_ALU, 4'd3, ID_MEM, 4'd4);
        run_cycles(10, 32'hFFFF_FFC0);
        check_val("t2_wid_c1", {28'd0, wid_log[1]}, {28'd0, ID_ALU});
        check_val("t2_wid_c6", {28'd0, wid_log[6]}, {28'd0, ID_ALU});
        check_val("t2_read_first", read_first, 32'd7);
        check_val("t2_n_read", n_read, 32'd1);
        check_val("t2_done_cyc", done_cyc, 32'd8);
        check_val("t2_last", {16'd0, last_data}, 32'hBEEF);

        // Source never valid: timeout.
        bus_data = 16'h5555;
        start_req(ID_MEM, 4'd5, ID_ALU, 4'd6);
        run_cycles(20, 32'h0000_0000);
        check_val("t3_to_cyc", to_cyc, 32'd17);
        check_val("t3_n_to", n_to, 32'd1);
        check_val("t3_n_done", n_done, 32'd0);
        check_val("t3_wid_c16", {28'd0, wid_log[16]}, {28'd0, ID_MEM});
        check_val("t3_wid_c17", {28'd0, wid_log[17]}, {28'd0, ID_NONE});
        check_val("t3_last", {16'd0, last_data}, 32'hBEEF);

        // Success on the final counted cycle wins over timeout.
        bus_data = 16'h0F0F;
        start_req(ID_REGFILE, 4'd1, ID_MEM, 4'd2);
        run_cycles(20, 32'hFFFF_8000);
        check_val("t4_done_cyc", done_cyc, 32'd17);
        check_val("t4_n_to", n_to, 32'd0);
        check_val("t4_last", {16'd0, last_data}, 32'h0F0F);

        // Valid drops in that final TRANSFER: timeout, no capture.
        bus_data = 16'hAAAA;
        start_req(ID_REGFILE, 4'd1, ID_MEM, 4'd2);
        run_cycles(20, 32'h0000_8000);
        check_val("t5_to_cyc", to_cyc, 32'd17);
        check_val("t5_n_done", n_done, 32'd0);
        check_val("t5_last", {16'd0, last_data}, 32'h0F0F);

        // Illegal requests: same unit, then missing source.
        start_req(ID_ALU, 4'd1, ID_ALU, 4'd2);
        run_cycles(4, 32'hFFFF_FFFF);
        check_val("t6_err_cyc", err_cyc, 32'd1);
        check_val("t6_n_err", n_err, 32'd1);
        check_val("t6_n_to", n_to, 32'd0);
        check_val("t6_n_bus", n_bus, 32'd0);
        start_req(ID_NONE, 4'd1, ID_MEM, 4'd2);
        run_cycles(4, 32'hFFFF_FFFF);
        check_val("t6b_err_cyc", err_cyc, 32'd1);
        check_val("t6b_n_done", n_done, 32'd0);

        // Valid dropped during TRANSFER once, then retried.
        bus_data = 16'hC0DE;
        start_req(ID_MEM, 4'd7, ID_REGFILE, 4'd8);
        run_cycles(8, 32'hFFFF_FFFA);
        check_val("t7_n_read", n_read, 32'd2);
        check_val("t7_done_cyc", done_cyc, 32'd5);
        check_val("t7_n_done", n_done, 32'd1);
        check_val("t7_last", {16'd0, last_data}, 32'hC0DE);

        // Reset while in TRANSFER.
        bus_data = 16'h9999;
        start_req(ID_REGFILE, 4'd2, ID_ALU, 4'd1);
        bus_valid = 1'b1;
        @(negedge clk);
        check_val("t8_in_xfer", {28'd0, read_id}, {28'd0, ID_ALU});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus_valid = 1'b0;
        check_val("t8_ready", {31'd0, req_ready}, 32'd1);
        check_val("t8_busy", {31'd0, busy}, 32'd0);
        check_val("t8_last", {16'd0, last_data}, 32'h0);
        check_val("t8_bus", {16'd0, write_id, write_command, read_id, read_command}, 32'h0);
        run_cycles(4, 32'h0000_0000);
        check_val("t8_pulses", n_done + n_to + n_err, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
